// File: rtl/mpu_pkg.sv
// Shared constants and types for the MPU matrix add/sub sequencer.
// Optional build macro used by this slice: MPU_SAT_EN (saturating lanes).
package mpu_pkg;
  localparam int MPU_DIM    = 5;
  localparam int MPU_ELEMS  = MPU_DIM * MPU_DIM;
  localparam int MPU_DATA_W = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int mpu_beats(input int lanes);
    return (MPU_ELEMS + lanes - 1) / lanes;
  endfunction
endpackage

// File: rtl/mpu_lane_alu.sv
// One signed element add/sub lane with overflow detection.
// MPU_SAT_EN defined: overflowing results clamp; otherwise they wrap.
module mpu_lane_alu
  import mpu_pkg::*;
#(
  parameter int DATA_W = MPU_DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              op,
  output logic [DATA_W-1:0] y,
  output logic              ovf
);
  logic [DATA_W:0] a_ext;
  logic [DATA_W:0] b_ext;
  logic [DATA_W:0] sum;

  always_comb begin
    a_ext = {a[DATA_W-1], a};
    b_ext = {b[DATA_W-1], b};
    sum   = (op == OP_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);
    // One guard bit is enough: the exact result always fits DATA_W+1 bits.
    ovf   = sum[DATA_W] ^ sum[DATA_W-1];
`ifdef MPU_SAT_EN
    if (ovf) begin
      y = sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      y = sum[DATA_W-1:0];
    end
`else
    y = sum[DATA_W-1:0];
`endif
  end
endmodule

// File: rtl/mpu_add_sequencer.sv
// 5x5 matrix add/sub sequenced over LANES shared lane ALUs; holds result until consumed.
// MPU_SAT_EN (see mpu_lane_alu) selects saturating instead of wrapping elements.
module mpu_add_sequencer
  import mpu_pkg::*;
#(
  parameter int LANES  = 5,
  parameter int DATA_W = MPU_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_op,
  input  logic [MPU_ELEMS*DATA_W-1:0] matrix_a,
  input  logic [MPU_ELEMS*DATA_W-1:0] matrix_b,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [MPU_ELEMS*DATA_W-1:0] result,
  output logic                        res_ovf,
  output logic                        busy
);
  localparam int BEATS  = mpu_beats(LANES);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int ELEM_W = $clog2(MPU_ELEMS);
  localparam int IDX_W  = $clog2(MPU_ELEMS + LANES);

  state_t            state_reg, state_next;
  logic [BEAT_W-1:0] beat_reg;
  logic              op_reg;
  logic              ovf_reg;
  logic [DATA_W-1:0] a_mem   [MPU_ELEMS];
  logic [DATA_W-1:0] b_mem   [MPU_ELEMS];
  logic [DATA_W-1:0] res_mem [MPU_ELEMS];

  logic [LANES-1:0]  lane_en;
  logic [LANES-1:0]  lane_ovf;
  logic [ELEM_W-1:0] lane_sel [LANES];
  logic [DATA_W-1:0] lane_y   [LANES];

  logic cmd_fire;
  logic last_beat;

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign last_beat = (beat_reg == BEAT_W'(BEATS - 1));

  always_comb begin
    state_next = state_reg;
    cmd_ready  = 1'b0;
    res_valid  = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_beat) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      beat_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (cmd_fire || (state_reg == RUN && last_beat)) begin
        beat_reg <= '0;
      end else if (state_reg == RUN) begin
        beat_reg <= beat_reg + 1'b1;
      end
    end
  end

  // Operands are only read during RUN, so they need no reset.
  always_ff @(posedge clk) begin
    if (cmd_fire) begin
      op_reg <= cmd_op;
      for (int e = 0; e < MPU_ELEMS; e++) begin
        a_mem[e] <= matrix_a[DATA_W*e +: DATA_W];
        b_mem[e] <= matrix_b[DATA_W*e +: DATA_W];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [IDX_W-1:0] idx;
      assign idx          = IDX_W'(beat_reg) * IDX_W'(LANES) + IDX_W'(gi);
      assign lane_en[gi]  = (idx < IDX_W'(MPU_ELEMS));
      assign lane_sel[gi] = lane_en[gi] ? idx[ELEM_W-1:0] : '0;

      mpu_lane_alu #(
        .DATA_W(DATA_W)
      ) u_alu (
        .a  (a_mem[lane_sel[gi]]),
        .b  (b_mem[lane_sel[gi]]),
        .op (op_reg),
        .y  (lane_y[gi]),
        .ovf(lane_ovf[gi])
      );
    end

    for (gi = 0; gi < MPU_ELEMS; gi++) begin : g_res
      assign result[DATA_W*gi +: DATA_W] = res_mem[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_reg <= 1'b0;
      for (int e = 0; e < MPU_ELEMS; e++) res_mem[e] <= '0;
    end else if (cmd_fire) begin
      ovf_reg <= 1'b0;
      for (int e = 0; e < MPU_ELEMS; e++) res_mem[e] <= '0;
    end else if (state_reg == RUN) begin
      // Lanes past element 24 on a partial last beat are masked out here.
      ovf_reg <= ovf_reg | (|(lane_ovf & lane_en));
      for (int l = 0; l < LANES; l++) begin
        if (lane_en[l]) res_mem[lane_sel[l]] <= lane_y[l];
      end
    end
  end

  assign res_ovf = ovf_reg;
endmodule

// File: tb/tb_mpu_add_sequencer.sv
// Self-checking bench for mpu_add_sequencer: vector table, corner sequences, random vs model.
// Honors MPU_SAT_EN the same way as the design build.
module tb_mpu_add_sequencer;
  localparam int NE = 25;
  localparam int W  = 8;
  localparam int VW = NE * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_op = 1'b0;
  logic [VW-1:0] matrix_a = '0;
  logic [VW-1:0] matrix_b = '0;

  logic          cmd_valid = 1'b0, res_ready = 1'b0;
  logic          cmd_ready, res_valid, res_ovf, busy;
  logic [VW-1:0] result;

  logic          cmd_valid7 = 1'b0, res_ready7 = 1'b0;
  logic          cmd_ready7, res_valid7, res_ovf7, busy7;
  logic [VW-1:0] result7;

  int tests = 0;
  int fails = 0;
  int txn   = 0;

  always #5 clk = ~clk;

  mpu_add_sequencer #(.LANES(5), .DATA_W(W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .matrix_a(matrix_a), .matrix_b(matrix_b), .res_valid(res_valid), .res_ready(res_ready),
    .result(result), .res_ovf(res_ovf), .busy(busy)
  );

  mpu_add_sequencer #(.LANES(7), .DATA_W(W)) dut_l7 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid7), .cmd_ready(cmd_ready7), .cmd_op(cmd_op),
    .matrix_a(matrix_a), .matrix_b(matrix_b), .res_valid(res_valid7), .res_ready(res_ready7),
    .result(result7), .res_ovf(res_ovf7), .busy(busy7)
  );

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: exact integer arithmetic, then clamp or wrap.
  function automatic void model(input logic op, input logic [VW-1:0] a, input logic [VW-1:0] b,
                                output logic [VW-1:0] r, output logic ovf);
    r   = '0;
    ovf = 1'b0;
    for (int e = 0; e < NE; e++) begin
      int x, y, s;
      x = $signed(a[W*e +: W]);
      y = $signed(b[W*e +: W]);
      s = op ? (x - y) : (x + y);
      if (s > 127 || s < -128) begin
        ovf = 1'b1;
`ifdef MPU_SAT_EN
        s = (s > 127) ? 127 : -128;
`endif
      end
      r[W*e +: W] = s[7:0];
    end
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < NE; i++) v[W*i +: W] = 8'($urandom);
    if ($urandom_range(0, 2) == 0) v = v & {NE{8'h1F}};
    return v;
  endfunction

  function automatic logic [VW-1:0] fill(input logic [7:0] val);
    return {NE{val}};
  endfunction

  // which=0: LANES=5 instance, which=1: LANES=7 instance.
  task automatic run(input int which, input logic op, input logic [VW-1:0] a, input logic [VW-1:0] b,
                     output logic [VW-1:0] r, output logic ovf, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!(which ? cmd_ready7 : cmd_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    cmd_op = op; matrix_a = a; matrix_b = b;
    if (which) cmd_valid7 = 1'b1; else cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_valid7 = 1'b0;
    chk("busy_after_cmd", which ? busy7 : busy, 1'b1);
    chk("cmd_ready_in_run", which ? cmd_ready7 : cmd_ready, 1'b0);
    matrix_a = rand_vec(); matrix_b = rand_vec(); cmd_op = ~op;
    lat = 0;
    while (!(which ? res_valid7 : res_valid) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    r   = which ? result7 : result;
    ovf = which ? res_ovf7 : res_ovf;
    if (which) res_ready7 = 1'b1; else res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0; res_ready7 = 1'b0;
    chk("cmd_ready_after_res", which ? cmd_ready7 : cmd_ready, 1'b1);
    txn++;
    $display("[TB] txn %0d lanes=%0d op=%0d ovf=%0d lat=%0d", txn, which ? 7 : 5, op, ovf, lat);
  endtask

  typedef struct {
    logic          op;
    logic [VW-1:0] a;
    logic [VW-1:0] b;
    logic [VW-1:0] exp_r;
    logic          exp_ovf;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [VW-1:0] r, er, held;
    logic          o, eo;
    int            lat;

    // Directed vectors with hand-derived expectations.
    vecs[0] = '{op: 1'b0, a: fill(8'd3), b: fill(8'd4), exp_r: fill(8'd7), exp_ovf: 1'b0};
    vecs[1].op = 1'b1; vecs[1].exp_ovf = 1'b0;
    for (int e = 0; e < NE; e++) begin
      vecs[1].a[W*e +: W]     = 8'(e);
      vecs[1].b[W*e +: W]     = 8'(2 * e);
      vecs[1].exp_r[W*e +: W] = 8'(-e);
    end
    vecs[2] = '{op: 1'b0, a: '0, b: '0, exp_r: '0, exp_ovf: 1'b1};
    vecs[2].a[7:0] = 8'd100; vecs[2].b[7:0] = 8'd100;
`ifdef MPU_SAT_EN
    vecs[2].exp_r[7:0] = 8'h7F;
`else
    vecs[2].exp_r[7:0] = 8'hC8;
`endif
    vecs[3] = '{op: 1'b1, a: '0, b: '0, exp_r: '0, exp_ovf: 1'b1};
    vecs[3].a[7:0] = 8'h80; vecs[3].b[7:0] = 8'h01;
    vecs[3].a[W*24 +: W] = 8'h7F; vecs[3].b[W*24 +: W] = 8'hFF;
`ifdef MPU_SAT_EN
    vecs[3].exp_r[7:0] = 8'h80; vecs[3].exp_r[W*24 +: W] = 8'h7F;
`else
    vecs[3].exp_r[7:0] = 8'h7F; vecs[3].exp_r[W*24 +: W] = 8'h80;
`endif
    vecs[4] = '{op: 1'b0, a: fill(8'h7F), b: fill(8'h80), exp_r: fill(8'hFF), exp_ovf: 1'b0};

    // Reset state
    #2;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_result", result, '0);
    chk("rst_res_ovf", res_ovf, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run(0, vecs[i].op, vecs[i].a, vecs[i].b, r, o, lat);
      chk($sformatf("vec%0d_result", i), r, vecs[i].exp_r);
      chk($sformatf("vec%0d_ovf", i), o, vecs[i].exp_ovf);
      chk($sformatf("vec%0d_latency", i), lat, 5);
    end

    // Partial last beat on the LANES=7 instance.
    run(1, 1'b0, fill(8'd1), fill(8'd1), r, o, lat);
    chk("l7_result", r, fill(8'd2));
    chk("l7_ovf", o, 1'b0);
    chk("l7_latency", lat, 4);

    // Back-pressure: result held while cmd_valid and matrix_a churn.
    @(negedge clk);
    cmd_op = 1'b0; matrix_a = vecs[0].a; matrix_b = vecs[0].b; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("hold_latency", lat, 5);
    held = result;
    chk("hold_initial", held, fill(8'd7));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      cmd_valid = 1'b1; matrix_a = rand_vec();
      @(posedge clk); #1;
      chk("hold_result", result, held);
      chk("hold_cmd_ready", cmd_ready, 1'b0);
      chk("hold_res_valid", res_valid, 1'b1);
    end
    @(negedge clk);
    cmd_valid = 1'b0; res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("release_cmd_ready", cmd_ready, 1'b1);
    chk("release_res_valid", res_valid, 1'b0);
    $display("[TB] txn %0d backpressure hold done", ++txn);

    // Asynchronous reset during beat 2.
    @(negedge clk);
    cmd_op = 1'b0; matrix_a = vecs[0].a; matrix_b = vecs[0].b; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_res_valid", res_valid, 1'b0);
    chk("midrst_result", result, '0);
    chk("midrst_cmd_ready", cmd_ready, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] txn %0d reset during run", ++txn);
    run(0, vecs[1].op, vecs[1].a, vecs[1].b, r, o, lat);
    chk("postrst_result", r, vecs[1].exp_r);
    chk("postrst_ovf", o, vecs[1].exp_ovf);
    chk("postrst_latency", lat, 5);

    // Randomized commands on both instances.
    for (int i = 0; i < 40; i++) begin
      logic [VW-1:0] a, b;
      logic          op;
      int            which;
      which = (i % 4 == 3) ? 1 : 0;
      a = rand_vec(); b = rand_vec(); op = 1'($urandom);
      model(op, a, b, er, eo);
      run(which, op, a, b, r, o, lat);
      chk("rand_result", r, er);
      chk("rand_ovf", o, eo);
      chk("rand_latency", lat, which ? 4 : 5);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
